// File: rtl/keypad_pkg.sv
// Shared keypad constants, FSM state type and key-decode helpers.
// The lock controller imports the same KEY_* codes.
package keypad_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd13;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StWaitRelease
    } state_e;

    // Rows 0-2 hold digits 1-9 left to right; row 3 is *, 0, #.
    function automatic logic [3:0] decode_key(logic [1:0] row, logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            unique case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic one_low(logic [3:0] rows);
        return $countones(~rows) == 1;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad rows; resets to idle (all high).
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 4'hf;
            q    <= 4'hf;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 3x4 matrix keypad scanner: column scan, press/release debounce, single-cycle key code.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] keycode
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DwellLast  = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BounceLast = BW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    row_s;
    logic [1:0]    low_idx;
    logic [1:0]    col_next;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StScan;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            dwell_q <= '0;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) low_idx = 2'(i);
        end
    end

    assign col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign col_out  = ~(3'b001 << col_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        keycode = KEY_NONE;
        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    // Only a single low row is a valid press; none or several are ignored.
                    if (one_low(row_s)) begin
                        row_d   = low_idx;
                        deb_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDebounce: begin
                if (row_s != ~(4'b0001 << row_q)) begin
                    state_d = StScan;
                    dwell_d = '0;
                    deb_d   = '0;
                    col_d   = col_next;
                end else if (deb_q == BounceLast) begin
                    state_d = StEmit;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            StEmit: begin
                keycode = decode_key(row_q, col_q);
                deb_d   = '0;
                state_d = StWaitRelease;
            end
            StWaitRelease: begin
                if (row_s != 4'hf) begin
                    deb_d = '0;
                end else if (deb_q == BounceLast) begin
                    state_d = StScan;
                    dwell_d = '0;
                    deb_d   = '0;
                    col_d   = col_next;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = StScan;
        endcase
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench: physical keypad model driving row_in, procedural reference scanner.
module tb_keypad_encoder;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] keycode;

    typedef struct {
        int          start;
        logic [11:0] mask;
    } ev_t;

    ev_t         plan[$];
    logic [11:0] pressed = '0;
    logic [3:0]  s1, s2;
    logic [3:0]  dut_emits[$];
    int          model_emits;
    int          cyc;
    int          total = 0;
    int          bad = 0;
    int          keymap[4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{11, 0, 10}};

    keypad_encoder #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .keycode (keycode)
    );

    always #5 clk = ~clk;

    // Key (r,c) pulls row r low while column c is driven low.
    function automatic logic [3:0] rows_of(logic [11:0] p, logic [2:0] col);
        logic [3:0] r = 4'hf;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                if (p[i*3+j] && !col[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row_in = rows_of(pressed, col_out);

    function automatic logic [11:0] key_bit(int r, int c);
        logic [11:0] one = 12'b1;
        return one << (r * 3 + c);
    endfunction

    function automatic logic [11:0] mask_at(int c);
        logic [11:0] m = '0;
        foreach (plan[i]) if (plan[i].start <= c) m = plan[i].mask;
        return m;
    endfunction

    function automatic logic [2:0] col_pat(int c);
        logic [2:0] p = 3'b111;
        p[c] = 1'b0;
        return p;
    endfunction

    task automatic add_ev(input int s, input logic [11:0] m);
        ev_t e;
        e.start = s;
        e.mask  = m;
        plan.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Called just after a negedge: check this cycle, apply stimulus, advance one clock.
    task automatic step(input logic [2:0] exp_col, input logic [3:0] exp_key);
        logic [3:0] mrow;
        check("col_out", 32'(col_out), 32'(exp_col));
        check("keycode", 32'(keycode), 32'(exp_key));
        if (keycode != KEY_NONE) dut_emits.push_back(keycode);
        if (exp_key != KEY_NONE) model_emits++;
        pressed = mask_at(cyc);
        mrow    = rows_of(pressed, exp_col);
        @(posedge clk);
        s2 = s1;
        s1 = mrow;
        @(negedge clk);
        cyc++;
    endtask

    // Reference scanner written as a straight-line program over columns and key events.
    task automatic run_model(input int budget, input int stop_deb);
        int         col_m;
        int         r_m;
        int         cnt;
        logic [3:0] rs;
        bit         got;
        col_m = 0;
        cyc   = 0;
        s1    = 4'hf;
        s2    = 4'hf;
        while (cyc < budget) begin
            got = 0;
            for (int d = 0; d < SD; d++) begin
                rs = s2;
                step(col_pat(col_m), KEY_NONE);
                if (d == SD - 1 && $countones(~rs) == 1) begin
                    got = 1;
                    for (int i = 0; i < 4; i++) if (!rs[i]) r_m = i;
                end
            end
            if (!got) begin
                col_m = (col_m + 1) % 3;
                continue;
            end
            for (int i = 0; i < DB; i++) begin
                if (stop_deb >= 0 && i == stop_deb) return;
                rs = s2;
                step(col_pat(col_m), KEY_NONE);
                if ($countones(~rs) != 1 || rs[r_m]) begin
                    got = 0;
                    break;
                end
            end
            if (!got) begin
                col_m = (col_m + 1) % 3;
                continue;
            end
            step(col_pat(col_m), 4'(keymap[r_m][col_m]));
            cnt = 0;
            while (cnt < DB && cyc < budget) begin
                rs = s2;
                step(col_pat(col_m), KEY_NONE);
                cnt = (rs == 4'hf) ? cnt + 1 : 0;
            end
            col_m = (col_m + 1) % 3;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_episode();
        dut_emits.delete();
        model_emits = 0;
        pressed = '0;
        do_reset();
    endtask

    initial begin
        int          t;
        int          sel;
        logic [11:0] m;
        @(negedge clk);

        // Key 5 held long: one emission, column frozen until release.
        plan.delete();
        add_ev(0, key_bit(1, 1));
        add_ev(100, '0);
        start_episode();
        run_model(160, -1);
        check("k5_count", dut_emits.size(), 1);
        if (dut_emits.size() >= 1) check("k5_code", 32'(dut_emits[0]), 5);

        // Short bounce on key 1 aborts debounce.
        plan.delete();
        add_ev(0, key_bit(0, 0));
        add_ev(5, '0);
        start_episode();
        run_model(60, -1);
        check("bounce_count", dut_emits.size(), 0);

        // Hash, release, then star.
        plan.delete();
        add_ev(0, key_bit(3, 2));
        add_ev(40, '0);
        add_ev(50, key_bit(3, 0));
        add_ev(90, '0);
        start_episode();
        run_model(160, -1);
        check("hs_count", dut_emits.size(), 2);
        if (dut_emits.size() >= 2) begin
            check("hs_first", 32'(dut_emits[0]), 10);
            check("hs_second", 32'(dut_emits[1]), 11);
        end

        // Two rows low in the same column: rejected.
        plan.delete();
        add_ev(0, key_bit(0, 0) | key_bit(1, 0));
        add_ev(80, '0);
        start_episode();
        run_model(100, -1);
        check("ghost_count", dut_emits.size(), 0);

        // Reset in the middle of debounce, key 2 kept held.
        plan.delete();
        add_ev(0, key_bit(0, 1));
        start_episode();
        run_model(200, 3);
        check("rst_pre_count", dut_emits.size(), 0);
        rst = 1'b0;
        #1;
        check("rst_keycode", 32'(keycode), 32'(KEY_NONE));
        check("rst_col", 32'(col_out), 32'(3'b110));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dut_emits.delete();
        model_emits = 0;
        run_model(60, -1);
        check("rst_post_count", dut_emits.size(), 1);
        if (dut_emits.size() >= 1) check("rst_post_code", 32'(dut_emits[0]), 2);

        // Partial release during wait-release must not re-emit.
        plan.delete();
        add_ev(0, key_bit(1, 1));
        add_ev(40, '0);
        add_ev(45, key_bit(1, 1));
        add_ev(70, '0);
        start_episode();
        run_model(140, -1);
        check("rel_count", dut_emits.size(), 1);
        if (dut_emits.size() >= 1) check("rel_code", 32'(dut_emits[0]), 5);

        // Random key sequences, including idle gaps and multi-key presses.
        for (int e = 0; e < 6; e++) begin
            plan.delete();
            t = 0;
            for (int k = 0; k < 6; k++) begin
                sel = int'($urandom_range(0, 3));
                m = '0;
                if (sel != 0) m = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                if (sel == 3) m |= key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                add_ev(t, m);
                t += int'($urandom_range(2, 45));
            end
            add_ev(t, '0);
            start_episode();
            run_model(t + 60, -1);
            check("rnd_count", dut_emits.size(), model_emits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven before advancing.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required for press and for release.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port row_in, input, 4 bits: keypad rows, active-low (pulled up externally), asynchronous to clk.
REQ-006 SHALL have port col_out, output, 3 bits: keypad columns, active-low, exactly one bit low at any time.
REQ-007 SHALL have port keycode, output, 4 bits: key code to lock controller; 0-9 digits, 10 hash, 11 star, 13 no command.

Function
REQ-008 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value (row_s).
REQ-009 SHALL use key map row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#; column 0 leftmost, row 0 topmost.
REQ-010 SHALL implement states SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-011 SCAN: SHALL drive column c low for SCAN_DIV cycles, then advance c 0->1->2->0 with wrap-around.
REQ-012 SCAN: on the last dwell cycle of a column, if exactly one bit of row_s is low, SHALL latch row/column and enter DEBOUNCE, holding col_out.
REQ-013 SCAN: zero or two-plus low rows on the sampling cycle SHALL be ignored (no latch; ghost/multi-key rejection).
REQ-014 DEBOUNCE: SHALL count DEBOUNCE_CYCLES cycles; each cycle row_s must equal the latched one-hot-low pattern.
REQ-015 DEBOUNCE: any mismatch SHALL abort to SCAN with the dwell counter cleared and the column advanced to the next one.
REQ-016 DEBOUNCE complete SHALL enter EMIT; EMIT lasts exactly one cycle with keycode = decoded key.
REQ-017 keycode SHALL be 13 in every cycle not in EMIT; each accepted press yields exactly one non-13 cycle.
REQ-018 Latency: keycode valid exactly DEBOUNCE_CYCLES+1 cycles after the SCAN sampling cycle.
REQ-019 WAIT_RELEASE: SHALL hold col_out; require row_s = 4'b1111 for DEBOUNCE_CYCLES consecutive cycles; any low row restarts the count.
REQ-020 WAIT_RELEASE complete SHALL return to SCAN at the next column with dwell counter cleared.
REQ-021 A held key SHALL never auto-repeat; a second key pressed while first is held SHALL be ignored until full release.
REQ-022 Counters SHALL be sized $clog2 of their parameter (minimum 1 bit) and SHALL not wrap within a state.

Reset
REQ-023 On rst low, immediately: state SCAN, col_out = 3'b110, keycode = 13, dwell and debounce counters 0, synchronizer flops 4'b1111, latched row/column 0.
REQ-024 Reset mid-DEBOUNCE or mid-WAIT_RELEASE SHALL discard the pending key; no emission until a fresh full debounce.

Structure
REQ-025 Shared package keypad_pkg SHALL hold KEY_HASH = 10, KEY_STAR = 11, KEY_NONE = 13 and the state enumeration; the lock controller SHALL use the same constants.
REQ-026 One sub-module keypad_sync (4-bit 2-flop synchronizer, reset to all ones) SHALL be instantiated; the FSM, counters and decode stay in keypad_encoder.

Verification (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8)
REQ-027 Hold row1 low whenever col 1 is driven, for 100 cycles -> keycode = 5 for exactly one cycle 9 cycles after sampling; col_out frozen at 3'b101 until release.
REQ-028 Row0 low for 3 cycles during DEBOUNCE then high -> no emission; SCAN resumes at column 1 with 4-cycle dwell.
REQ-029 Press # (row3, col2), release 10 cycles, press * (row3, col0) -> keycode sequence 10 then 11, each single-cycle, 13 otherwise.
REQ-030 Rows 0 and 1 both low in column 0 -> no emission while both held.
REQ-031 rst low during DEBOUNCE -> same cycle keycode = 13, col_out = 3'b110; after rst high with key still held, emission occurs only after a complete new debounce.
REQ-032 During WAIT_RELEASE, rows high for 5 cycles then low again -> no second emission; release then requires 8 consecutive high cycles.
